// File: rtl/any1_inst_align.sv
// -----------------------------------------------------------------------------
// any1_inst_align
//
// Instruction-align stage between L1 fetch and decode. It takes one 512-bit
// cache line with its fetch ip and branch prediction. It then emits the line's
// 64-bit instructions one per cycle, starting at the fetch slot. Emission stops
// after slot 7 or after a predicted-taken branch. Each instruction is tagged
// with its ip, predicted next ip, stream id and a wrapping rob id (rid).
//
// Optional build macro:
//   ANY1_ALIGN_NOP_SKIP_EN - when defined, NOP slots (opcode 0x3F) are
//                            stepped over internally, one slot per cycle,
//                            with out_valid_o low and no rid increment.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                redirect; drops the line in progress
//   in_valid_i/in_ready_o  line handshake
//   in_line_i              cache line (8 x 64-bit instructions)
//   in_ip_i                fetch ip (bits [2:0] zero)
//   in_pip_i, in_pt_i      predicted target / predict-taken for the line
//   in_stream_i            stream id
//   out_valid_o/out_ready_i instruction handshake
//   out_ir_o               instruction word
//   out_ip_o, out_pip_o    instruction ip / predicted next ip
//   out_pt_o               predict-taken (only on the terminating instruction)
//   out_stream_o, out_rid_o stream id / rob id
//
// The opcode is taken as ir[7:0].
// -----------------------------------------------------------------------------
module any1_inst_align #(
  parameter int AWID  = 32,
  parameter int LINEW = 512,
  parameter int RIDW  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [LINEW-1:0] in_line_i,
  input  logic [AWID-1:0]  in_ip_i,
  input  logic [AWID-1:0]  in_pip_i,
  input  logic             in_pt_i,
  input  logic [5:0]       in_stream_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      out_ir_o,
  output logic [AWID-1:0]  out_ip_o,
  output logic [AWID-1:0]  out_pip_o,
  output logic             out_pt_o,
  output logic [5:0]       out_stream_o,
  output logic [RIDW-1:0]  out_rid_o
);

  localparam int BW = AWID - 6;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [LINEW-1:0]  line_q, line_d;
  logic [BW-1:0]     base_q, base_d;
  logic [2:0]        slot_q, slot_d;
  logic [AWID-1:0]   pip_q, pip_d;
  logic              pt_q, pt_d;
  logic [5:0]        stream_q, stream_d;
  logic [RIDW-1:0]   rid_q, rid_d;

  logic [63:0]       ir_cur;
  logic [7:0]        op;
  logic              is_br, is_last, skip, emit, fire, accept;
  logic [AWID-1:0]   cur_ip, ip_p8;

  // Low ip bits are always zero and carry no information.
  logic unused_ip_lo;
  assign unused_ip_lo = ^in_ip_i[2:0];

  assign ir_cur = line_q[{slot_q, 6'd0} +: 64];
  assign op     = ir_cur[7:0];
  // Branch opcodes: 0x40 and 0x48..0x4F.
  assign is_br  = (op == 8'h40) || (op[7:3] == 5'b01001);
  assign is_last = (slot_q == 3'd7) || (pt_q && is_br);

`ifdef ANY1_ALIGN_NOP_SKIP_EN
  assign skip = (op == 8'h3F);
`else
  assign skip = 1'b0;
`endif

  assign emit   = (state_q == EMIT);
  assign cur_ip = {base_q, slot_q, 3'b000};
  assign ip_p8  = cur_ip + AWID'(8);

  // Handshake: in_ready depends combinationally on out_ready (zero-bubble
  // reload on the last transfer) but never on in_valid.
  assign out_valid_o = emit && !skip;
  assign fire        = out_valid_o && out_ready_i;
  assign in_ready_o  = !flush_i && (!emit || (fire && is_last));
  assign accept      = in_valid_i && in_ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      line_q   <= '0;
      base_q   <= '0;
      slot_q   <= '0;
      pip_q    <= '0;
      pt_q     <= 1'b0;
      stream_q <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      base_q   <= base_d;
      slot_q   <= slot_d;
      pip_q    <= pip_d;
      pt_q     <= pt_d;
      stream_q <= stream_d;
      rid_q    <= rid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    base_d   = base_q;
    slot_d   = slot_q;
    pip_d    = pip_q;
    pt_d     = pt_q;
    stream_d = stream_q;
    // A transfer on a flush cycle still consumes a rid.
    rid_d    = fire ? rid_q + RIDW'(1) : rid_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d  = EMIT;
      line_d   = in_line_i;
      base_d   = in_ip_i[AWID-1:6];
      slot_d   = in_ip_i[5:3];
      pip_d    = in_pip_i;
      pt_d     = in_pt_i;
      stream_d = in_stream_i;
    end else if (emit) begin
      if (fire) begin
        if (is_last) state_d = IDLE;
        else         slot_d  = slot_q + 3'd1;
      end else if (skip) begin
        if (slot_q == 3'd7) state_d = IDLE;
        else                slot_d  = slot_q + 3'd1;
      end
    end
  end

  // Output logic: data fields are zero whenever nothing is presented.
  always_comb begin
    out_ir_o     = '0;
    out_ip_o     = '0;
    out_pip_o    = '0;
    out_pt_o     = 1'b0;
    out_stream_o = '0;
    out_rid_o    = '0;
    if (out_valid_o) begin
      out_ir_o     = ir_cur;
      out_ip_o     = cur_ip;
      out_stream_o = stream_q;
      out_rid_o    = rid_q;
      out_pt_o     = is_last && pt_q;
      out_pip_o    = (is_last && pt_q) ? pip_q : ip_p8;
    end
  end

endmodule
